// File: rtl/rob_commit_ctrl.sv
// Commit sequencer between the reorder-buffer head and the architectural register file.
// Retires at most one head entry every two cycles: register writes, store release/wait, and misprediction roll-back.
module rob_commit_ctrl #(
    parameter int ROB_ID_W     = 4,
    parameter int REG_IDX_W    = 5,
    parameter int DATA_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic [ROB_ID_W-1:0]  head_id,
    input  logic [1:0]           head_type,
    input  logic [REG_IDX_W-1:0] head_rd,
    input  logic [DATA_W-1:0]    head_value,
    input  logic                 head_mispredict,
    input  logic [DATA_W-1:0]    head_target_pc,
    input  logic                 lsb_store_done,
    output logic                 rob_pop,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_rd,
    output logic [DATA_W-1:0]    rf_value,
    output logic [ROB_ID_W-1:0]  rf_rob_id,
    output logic                 lsb_store_commit,
    output logic [ROB_ID_W-1:0]  lsb_store_id,
    output logic                 rollback_flag,
    output logic [DATA_W-1:0]    rollback_pc,
    output logic [31:0]          commit_count
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_WAIT_ST = 2'b01,
        S_FLUSH   = 2'b10
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       flush_cnt, flush_cnt_nxt;

    logic                   rob_pop_nxt;
    logic                   rf_we_nxt;
    logic [REG_IDX_W-1:0]   rf_rd_nxt;
    logic [DATA_W-1:0]      rf_value_nxt;
    logic [ROB_ID_W-1:0]    rf_rob_id_nxt;
    logic                   lsb_store_commit_nxt;
    logic [ROB_ID_W-1:0]    lsb_store_id_nxt;
    logic                   rollback_flag_nxt;
    logic [DATA_W-1:0]      rollback_pc_nxt;
    logic [31:0]            commit_count_nxt;

    // A head that was just popped is still presented for one cycle until the ROB advances.
    logic                   commit_take;
    assign commit_take = head_valid & head_ready & ~rob_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        flush_cnt_nxt        = flush_cnt;
        rob_pop_nxt          = 1'b0;
        rf_we_nxt            = 1'b0;
        rf_rd_nxt            = rf_rd;
        rf_value_nxt         = rf_value;
        rf_rob_id_nxt        = rf_rob_id;
        lsb_store_commit_nxt = 1'b0;
        lsb_store_id_nxt     = lsb_store_id;
        rollback_flag_nxt    = rollback_flag;
        rollback_pc_nxt      = rollback_pc;
        commit_count_nxt     = commit_count;

        if (rdy) begin
            case (state)
                S_IDLE: begin
                    if (commit_take) begin
                        if (head_type == 2'b01) begin
                            lsb_store_commit_nxt = 1'b1;
                            lsb_store_id_nxt     = head_id;
                            state_nxt            = S_WAIT_ST;
                        end else begin
                            // Reg-write, branch link and the reserved type all retire the same way.
                            rob_pop_nxt      = 1'b1;
                            commit_count_nxt = commit_count + 32'd1;
                            if (head_rd != '0) begin
                                rf_we_nxt     = 1'b1;
                                rf_rd_nxt     = head_rd;
                                rf_value_nxt  = head_value;
                                rf_rob_id_nxt = head_id;
                            end
                            if (head_type == 2'b10 && head_mispredict) begin
                                rollback_flag_nxt = 1'b1;
                                rollback_pc_nxt   = head_target_pc;
                                flush_cnt_nxt     = FLUSH_INIT;
                                state_nxt         = S_FLUSH;
                            end
                        end
                    end
                end
                S_WAIT_ST: begin
                    if (lsb_store_done) begin
                        rob_pop_nxt      = 1'b1;
                        commit_count_nxt = commit_count + 32'd1;
                        state_nxt        = S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        rollback_flag_nxt = 1'b0;
                        flush_cnt_nxt     = '0;
                        state_nxt         = S_IDLE;
                    end else begin
                        flush_cnt_nxt = flush_cnt - FLUSH_LAST;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rob_pop          <= 1'b0;
            rf_we            <= 1'b0;
            rf_rd            <= '0;
            rf_value         <= '0;
            rf_rob_id        <= '0;
            lsb_store_commit <= 1'b0;
            lsb_store_id     <= '0;
            rollback_flag    <= 1'b0;
            rollback_pc      <= '0;
            commit_count     <= '0;
        end else begin
            rob_pop          <= rob_pop_nxt;
            rf_we            <= rf_we_nxt;
            rf_rd            <= rf_rd_nxt;
            rf_value         <= rf_value_nxt;
            rf_rob_id        <= rf_rob_id_nxt;
            lsb_store_commit <= lsb_store_commit_nxt;
            lsb_store_id     <= lsb_store_id_nxt;
            rollback_flag    <= rollback_flag_nxt;
            rollback_pc      <= rollback_pc_nxt;
            commit_count     <= commit_count_nxt;
        end
    end

endmodule
